// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request FSM, redirect handling and decode-stage registers.
// Define FETCH_BUF_EN to add a one-entry prefetch buffer that keeps words fetched during a stall.
//
// state | meaning
// IDLE  | no request on the bus
// REQ   | request on the bus, returned word goes to decode
// DROP  | request on the bus, returned word is discarded (redirected away)
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [11:0]       redirect_addr,
  fetch_unit_if.master      imem,
  output logic [31:0]       inst,
  output logic [11:0]       pc,
  output logic              inst_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t      state_q;
  logic [11:0] fetch_pc_q;
  logic [11:0] addr_q;
  logic [31:0] inst_q;
  logic [11:0] pc_q;
  logic        inst_valid_q;
  logic [11:0] nxt_pc;
  logic [11:0] tgt;
`ifdef FETCH_BUF_EN
  logic [31:0] buf_word_q;
  logic [11:0] buf_addr_q;
  logic        buf_valid_q;
`endif

  assign nxt_pc         = fetch_pc_q + 12'd4;
  assign tgt            = redirect_addr & 12'hFFC;
  assign imem.imem_req  = (state_q != S_IDLE);
  assign imem.imem_addr = addr_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign inst_valid     = inst_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      addr_q       <= RESET_PC;
      inst_q       <= NOP;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
`ifdef FETCH_BUF_EN
      buf_word_q   <= NOP;
      buf_addr_q   <= RESET_PC;
      buf_valid_q  <= 1'b0;
`endif
    end else begin
      if (redirect) begin
        inst_q       <= NOP;
        inst_valid_q <= 1'b0;
`ifdef FETCH_BUF_EN
        buf_valid_q  <= 1'b0;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc_q <= tgt;
            if (!stall) begin
              state_q <= S_REQ;
              addr_q  <= tgt;
            end
          end else if (!stall) begin
`ifdef FETCH_BUF_EN
            if (buf_valid_q) begin
              inst_q       <= buf_word_q;
              pc_q         <= buf_addr_q;
              inst_valid_q <= 1'b1;
              buf_valid_q  <= 1'b0;
            end
`endif
            state_q <= S_REQ;
            addr_q  <= fetch_pc_q;
          end
        end
        S_REQ: begin
          if (redirect) begin
            fetch_pc_q <= tgt;
            if (!imem.imem_ack) begin
              state_q <= S_DROP;
            end else if (!stall) begin
              addr_q <= tgt;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (stall) begin
            // Word returned under stall: keep it if buffered, otherwise refetch later.
            if (imem.imem_ack) begin
`ifdef FETCH_BUF_EN
              buf_word_q  <= imem.imem_rdata;
              buf_addr_q  <= addr_q;
              buf_valid_q <= 1'b1;
              fetch_pc_q  <= nxt_pc;
`endif
              state_q <= S_IDLE;
            end
          end else if (imem.imem_ack) begin
            inst_q       <= imem.imem_rdata;
            pc_q         <= addr_q;
            inst_valid_q <= 1'b1;
            fetch_pc_q   <= nxt_pc;
            addr_q       <= nxt_pc;
          end else begin
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
          end
        end
        S_DROP: begin
          if (redirect) begin
            fetch_pc_q <= tgt;
          end
          // The stale word is thrown away; only then may the new address go out.
          if (imem.imem_ack) begin
            if (!stall) begin
              state_q <= S_REQ;
              addr_q  <= redirect ? tgt : fetch_pc_q;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns {20'hC0DE0, addr} so every word encodes its address.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_addr = 12'h000;
  logic [31:0] inst;
  logic [11:0] pc;
  logic        inst_valid;
  int          n_cmp = 0;
  int          n_mis = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem          (bus.master),
    .inst          (inst),
    .pc            (pc),
    .inst_valid    (inst_valid)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = {20'hC0DE0, bus.imem_addr};

  // {req, addr, valid, pc, inst}
  logic [57:0] obs;
  assign obs = {bus.imem_req, bus.imem_addr, inst_valid, pc, inst};

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got time %0t want completion", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    n_cmp++; if (obs !== {1'b0, 12'h000, 1'b0, 12'h000, NOP}) begin n_mis++; $display("FAIL reset_hold: got %h want %h", obs, {1'b0, 12'h000, 1'b0, 12'h000, NOP}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h000, 1'b0, 12'h000, NOP}) begin n_mis++; $display("FAIL reset_release: got %h want %h", obs, {1'b1, 12'h000, 1'b0, 12'h000, NOP}); end
  endtask

  task automatic test_sequential();
    logic [57:0] exp;
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {1'b1, 12'(4*(i+1)), 1'b1, 12'(4*i), {20'hC0DE0, 12'(4*i)}};
      n_cmp++; if (obs !== exp) begin n_mis++; $display("FAIL seq_%0d: got %h want %h", i, obs, exp); end
    end
  endtask

  task automatic test_redirect_same_cycle();
    redirect = 1'b1; redirect_addr = 12'h103;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h100, 1'b0, 12'h008, NOP}) begin n_mis++; $display("FAIL redir_bubble: got %h want %h", obs, {1'b1, 12'h100, 1'b0, 12'h008, NOP}); end
    redirect = 1'b0;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h104, 1'b1, 12'h100, 32'hC0DE0100}) begin n_mis++; $display("FAIL redir_target: got %h want %h", obs, {1'b1, 12'h104, 1'b1, 12'h100, 32'hC0DE0100}); end
  endtask

  task automatic test_drop();
    redirect = 1'b1; redirect_addr = 12'h010;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h010, 1'b0, 12'h100, NOP}) begin n_mis++; $display("FAIL drop_setup: got %h want %h", obs, {1'b1, 12'h010, 1'b0, 12'h100, NOP}); end
    bus.imem_ack = 1'b0; redirect_addr = 12'h200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (obs !== {1'b1, 12'h010, 1'b0, 12'h100, NOP}) begin n_mis++; $display("FAIL drop_hold_%0d: got %h want %h", i, obs, {1'b1, 12'h010, 1'b0, 12'h100, NOP}); end
      if (i == 2) bus.imem_ack = 1'b1;
      tick();
    end
    n_cmp++; if (obs !== {1'b1, 12'h200, 1'b0, 12'h100, NOP}) begin n_mis++; $display("FAIL drop_release: got %h want %h", obs, {1'b1, 12'h200, 1'b0, 12'h100, NOP}); end
    bus.imem_ack = 1'b0;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h200, 1'b0, 12'h100, NOP}) begin n_mis++; $display("FAIL req_no_ack: got %h want %h", obs, {1'b1, 12'h200, 1'b0, 12'h100, NOP}); end
  endtask

  task automatic test_stall();
    logic [57:0] exp;
    redirect = 1'b1; redirect_addr = 12'h01C; bus.imem_ack = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h020, 1'b1, 12'h01C, 32'hC0DE001C}) begin n_mis++; $display("FAIL stall_setup: got %h want %h", obs, {1'b1, 12'h020, 1'b1, 12'h01C, 32'hC0DE001C}); end
    bus.imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = (i == 2);
      tick();
      exp = {(i < 2), 12'h020, 1'b1, 12'h01C, 32'hC0DE001C};
      n_cmp++; if (obs !== exp) begin n_mis++; $display("FAIL stall_frozen_%0d: got %h want %h", i, obs, exp); end
    end
    bus.imem_ack = 1'b0; stall = 1'b0;
    tick();
`ifdef FETCH_BUF_EN
    exp = {1'b1, 12'h024, 1'b1, 12'h020, 32'hC0DE0020};
`else
    exp = {1'b1, 12'h020, 1'b1, 12'h01C, 32'hC0DE001C};
`endif
    n_cmp++; if (obs !== exp) begin n_mis++; $display("FAIL stall_release: got %h want %h", obs, exp); end
    bus.imem_ack = 1'b1;
    tick();
`ifdef FETCH_BUF_EN
    exp = {1'b1, 12'h028, 1'b1, 12'h024, 32'hC0DE0024};
`else
    exp = {1'b1, 12'h024, 1'b1, 12'h020, 32'hC0DE0020};
`endif
    n_cmp++; if (obs !== exp) begin n_mis++; $display("FAIL stall_after: got %h want %h", obs, exp); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_addr = 12'hFFE;
    tick();
    n_cmp++; if ({bus.imem_req, bus.imem_addr, inst_valid, inst} !== {1'b1, 12'hFFC, 1'b0, NOP}) begin n_mis++; $display("FAIL wrap_setup: got %h want %h", {bus.imem_req, bus.imem_addr, inst_valid, inst}, {1'b1, 12'hFFC, 1'b0, NOP}); end
    redirect = 1'b0;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h000, 1'b1, 12'hFFC, 32'hC0DE0FFC}) begin n_mis++; $display("FAIL wrap: got %h want %h", obs, {1'b1, 12'h000, 1'b1, 12'hFFC, 32'hC0DE0FFC}); end
  endtask

  task automatic test_reset_mid();
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h004, 1'b1, 12'h000, 32'hC0DE0000}) begin n_mis++; $display("FAIL rst_mid_setup: got %h want %h", obs, {1'b1, 12'h004, 1'b1, 12'h000, 32'hC0DE0000}); end
    bus.imem_ack = 1'b0;
    tick();
    bus.imem_ack = 1'b1;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h008, 1'b1, 12'h004, 32'hC0DE0004}) begin n_mis++; $display("FAIL rst_mid_pending: got %h want %h", obs, {1'b1, 12'h008, 1'b1, 12'h004, 32'hC0DE0004}); end
    bus.imem_ack = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++; if (obs !== {1'b0, 12'h000, 1'b0, 12'h000, NOP}) begin n_mis++; $display("FAIL rst_mid_async: got %h want %h", obs, {1'b0, 12'h000, 1'b0, 12'h000, NOP}); end
    bus.imem_ack = 1'b1;
    tick();
    tick();
    n_cmp++; if (obs !== {1'b0, 12'h000, 1'b0, 12'h000, NOP}) begin n_mis++; $display("FAIL rst_late_ack: got %h want %h", obs, {1'b0, 12'h000, 1'b0, 12'h000, NOP}); end
    bus.imem_ack = 1'b0; rst_n = 1'b1;
    tick();
    n_cmp++; if (obs !== {1'b1, 12'h000, 1'b0, 12'h000, NOP}) begin n_mis++; $display("FAIL rst_mid_restart: got %h want %h", obs, {1'b1, 12'h000, 1'b0, 12'h000, NOP}); end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    test_reset();
    test_sequential();
    test_redirect_same_cycle();
    test_drop();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
